// File: rtl/management_rx_frame_fifo_if.sv
// ============================================================================
// Module  : management_rx_frame_fifo_if
// Brief   : Receive-frame and byte-read signal bundle for the frame FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface management_rx_frame_fifo_if;
    logic        rx_start;
    logic        rx_data_valid;
    logic [2:0]  rx_bytes_valid;
    logic [31:0] rx_data;
    logic        rx_commit;
    logic        rx_drop;
    logic        rd_frame_valid;
    logic [12:0] rd_frame_len;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_frame_done;
    logic        rx_overflow;
    logic [15:0] drop_count;

    modport master (
        output rx_start, rx_data_valid, rx_bytes_valid, rx_data, rx_commit, rx_drop,
        output rd_en, rd_frame_done,
        input  rd_frame_valid, rd_frame_len, rd_data, rx_overflow, drop_count
    );

    modport slave (
        input  rx_start, rx_data_valid, rx_bytes_valid, rx_data, rx_commit, rx_drop,
        input  rd_en, rd_frame_done,
        output rd_frame_valid, rd_frame_len, rd_data, rx_overflow, drop_count
    );
endinterface

`default_nettype wire

// File: rtl/management_rx_frame_fifo.sv
// ============================================================================
// Module  : management_rx_frame_fifo
// Brief   : Word-wide receive frame buffer with commit/drop and a byte-wide
//           read side; frame lengths are queued in a header FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module management_rx_frame_fifo #(
    parameter int DATA_DEPTH = 1024,
    parameter int HDR_DEPTH  = 32
) (
    input  wire logic                    sys_clk,
    input  wire logic                    rst_n,
    management_rx_frame_fifo_if.slave    bus
);
    localparam int AW    = $clog2(DATA_DEPTH);
    localparam int HW    = $clog2(HDR_DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int HDR_W = HW + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RECEIVING = 2'd1,
        ST_DISCARD   = 2'd2
    } state_t;

    logic [31:0]      mem_q [DATA_DEPTH];
    logic [12:0]      hdr_mem_q [HDR_DEPTH];

    state_t           state_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_base_q, rd_ptr_q, rd_base_q;
    logic [13:0]      len_q;
    logic             rx_overflow_q;
    logic [15:0]      drop_count_q;
    logic [HDR_W-1:0] hdr_wr_q, hdr_rd_q;
    logic [1:0]       rd_byte_q;
    logic [12:0]      rd_cnt_q;
    logic             rd_frame_valid_q;
    logic [12:0]      rd_frame_len_q;
    logic [7:0]       rd_data_q;

    logic [PTR_W-1:0] wr_ptr_d;
    logic [13:0]      len_d;
    logic [13:0]      w_len_sum;
    logic [HDR_W-1:0] w_hdr_used;
    logic             w_full, w_hdr_full, w_recv, w_ovf, w_wr_en;
    logic             w_hdr_push, w_commit_full;
    logic             w_rd_done, w_rd_pop;
    logic [13:0]      w_words;

    always_comb begin
        w_full        = (wr_ptr_q - rd_base_q) == PTR_W'(DATA_DEPTH);
        w_hdr_used    = hdr_wr_q - hdr_rd_q;
        w_hdr_full    = w_hdr_used == HDR_W'(HDR_DEPTH);
        w_len_sum     = len_q + {11'd0, bus.rx_bytes_valid};
        w_recv        = (state_q == ST_RECEIVING) && !bus.rx_start;
        w_ovf         = w_recv && bus.rx_data_valid && (w_full || (w_len_sum > 14'd8191));
        w_wr_en       = w_recv && bus.rx_data_valid && !w_ovf;
        len_d         = w_wr_en ? w_len_sum : len_q;
        wr_ptr_d      = wr_ptr_q + (w_wr_en ? PTR_W'(1) : PTR_W'(0));
        // A word arriving with the commit counts toward the committed length.
        w_hdr_push    = w_recv && !w_ovf && bus.rx_commit && (len_d != 14'd0) && !w_hdr_full;
        w_commit_full = w_recv && !w_ovf && bus.rx_commit && (len_d != 14'd0) && w_hdr_full;
        w_rd_done     = bus.rd_frame_done && rd_frame_valid_q;
        w_rd_pop      = bus.rd_en && rd_frame_valid_q && !bus.rd_frame_done &&
                        (rd_cnt_q < rd_frame_len_q);
        w_words       = ({1'b0, rd_frame_len_q} + 14'd3) >> 2;
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr_en) mem_q[wr_ptr_q[AW-1:0]] <= bus.rx_data;
        if (w_hdr_push) hdr_mem_q[hdr_wr_q[HW-1:0]] <= len_d[12:0];
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            wr_base_q     <= '0;
            len_q         <= '0;
            rx_overflow_q <= 1'b0;
            drop_count_q  <= '0;
            hdr_wr_q      <= '0;
        end else begin
            rx_overflow_q <= 1'b0;
            if (bus.rx_start) begin
                wr_ptr_q <= wr_base_q;
                len_q    <= '0;
                state_q  <= ST_RECEIVING;
            end else begin
                case (state_q)
                    ST_RECEIVING: begin
                        if (w_ovf || w_commit_full) begin
                            wr_ptr_q      <= wr_base_q;
                            state_q       <= w_ovf ? ST_DISCARD : ST_IDLE;
                            rx_overflow_q <= 1'b1;
                            if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
                        end else if (w_hdr_push) begin
                            wr_ptr_q  <= wr_ptr_d;
                            wr_base_q <= wr_ptr_d;
                            hdr_wr_q  <= hdr_wr_q + HDR_W'(1);
                            state_q   <= ST_IDLE;
                        end else if (bus.rx_commit || bus.rx_drop) begin
                            wr_ptr_q <= wr_base_q;
                            state_q  <= ST_IDLE;
                        end else begin
                            wr_ptr_q <= wr_ptr_d;
                            len_q    <= len_d;
                        end
                    end
                    ST_DISCARD: begin
                        if (bus.rx_commit || bus.rx_drop) state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q         <= '0;
            rd_base_q        <= '0;
            rd_byte_q        <= '0;
            rd_cnt_q         <= '0;
            hdr_rd_q         <= '0;
            rd_frame_valid_q <= 1'b0;
            rd_frame_len_q   <= '0;
            rd_data_q        <= '0;
        end else if (w_rd_done) begin
            // Valid drops for one cycle so the next head length settles first.
            rd_ptr_q         <= rd_base_q + PTR_W'(w_words);
            rd_base_q        <= rd_base_q + PTR_W'(w_words);
            rd_byte_q        <= '0;
            rd_cnt_q         <= '0;
            hdr_rd_q         <= hdr_rd_q + HDR_W'(1);
            rd_frame_valid_q <= 1'b0;
            rd_frame_len_q   <= '0;
        end else begin
            rd_frame_valid_q <= (w_hdr_used != '0);
            rd_frame_len_q   <= (w_hdr_used != '0) ? hdr_mem_q[hdr_rd_q[HW-1:0]] : 13'd0;
            if (w_rd_pop) begin
                case (rd_byte_q)
                    2'd0:    rd_data_q <= mem_q[rd_ptr_q[AW-1:0]][31:24];
                    2'd1:    rd_data_q <= mem_q[rd_ptr_q[AW-1:0]][23:16];
                    2'd2:    rd_data_q <= mem_q[rd_ptr_q[AW-1:0]][15:8];
                    default: rd_data_q <= mem_q[rd_ptr_q[AW-1:0]][7:0];
                endcase
                rd_byte_q <= rd_byte_q + 2'd1;
                rd_cnt_q  <= rd_cnt_q + 13'd1;
                if (rd_byte_q == 2'd3) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign bus.rd_frame_valid = rd_frame_valid_q;
    assign bus.rd_frame_len   = rd_frame_len_q;
    assign bus.rd_data        = rd_data_q;
    assign bus.rx_overflow    = rx_overflow_q;
    assign bus.drop_count     = drop_count_q;
endmodule

`default_nettype wire
